// File: rtl/z80_idx_mem_seq.sv
// z80_idx_mem_seq: multi-cycle sequencer for the Z80 indexed-memory loads and
// stores LD (IX/IY+d),r / LD r,(IX/IY+d) / LD (IX/IY+d),n.
// It forms EA = index + sign-extended d, runs one memory machine cycle that
// stretches on mem_wait in its last T-state, then pulses done with the result.
//
// Handshake: start is sampled only while busy=0 (IDLE). Once accepted, busy
// rises the next cycle and stays high through the single-cycle done pulse.
// start is ignored while busy=1, so a held start re-launches the cycle after done.
`timescale 1ns/1ps

module z80_idx_mem_seq #(
   parameter int ADDR_WIDTH  = 16,
   parameter int ADDR_DELAY  = 5,
   parameter int MEM_TSTATES = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic                  use_iy,
   input  logic [ADDR_WIDTH-1:0] reg_ix,
   input  logic [ADDR_WIDTH-1:0] reg_iy,
   input  logic [7:0]            disp,
   input  logic [7:0]            src_data,
   input  logic [7:0]            imm,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic [7:0]            mem_wdata,
   input  logic [7:0]            mem_rdata,
   input  logic                  mem_wait,
   output logic                  done,
   output logic                  err,
   output logic                  rd_we,
   output logic [7:0]            rd_data,
   output logic [2:0]            ip_delta
);

   // Operation encodings
   localparam logic [1:0] MODE_ST_REG = 2'd0;
   localparam logic [1:0] MODE_LD_REG = 2'd1;
   localparam logic [1:0] MODE_ST_IMM = 2'd2;
   localparam logic [1:0] MODE_ILLEGAL = 2'd3;

   // FSM states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_MEM  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // The ADDR counter counts ADDR_DELAY-1 down to 0; keep it at least one bit
   // wide so the design still elaborates when ADDR_DELAY is 0 or 1.
   localparam int ACW = (ADDR_DELAY > 1) ? $clog2(ADDR_DELAY) : 1;
   localparam int TCW = $clog2(MEM_TSTATES + 1);
   localparam logic [ACW-1:0] ACNT_LOAD  = ACW'((ADDR_DELAY > 0) ? ADDR_DELAY - 1 : 0);
   localparam logic [TCW-1:0] TCNT_FIRST = TCW'(1);
   localparam logic [TCW-1:0] TCNT_LAST  = TCW'(MEM_TSTATES);

   // Current FSM state; kept as a plain named register so checkers can bind to it.
   logic [1:0]            state;
   logic [1:0]            mode_q;
   logic [ADDR_WIDTH-1:0] ea_q;
   logic [7:0]            wdata_q;
   logic [ACW-1:0]        acnt;
   logic [TCW-1:0]        tcnt;

   logic [ADDR_WIDTH-1:0] base_sel;
   logic [ADDR_WIDTH-1:0] disp_ext;
   logic [ADDR_WIDTH-1:0] ea_calc;
   logic [7:0]            wdata_calc;
   logic                  mem_enter;
   logic [1:0]            nxt_mode;
   logic [ADDR_WIDTH-1:0] nxt_ea;
   logic [7:0]            nxt_wdata;

   // IP increment reported with done for each operation.
   function automatic logic [2:0] ip_for(input logic [1:0] m);
      case (m)
         MODE_ST_REG: ip_for = 3'd3;
         MODE_LD_REG: ip_for = 3'd3;
         MODE_ST_IMM: ip_for = 3'd4;
         default:     ip_for = 3'd0;
      endcase
   endfunction

   // Effective address and write data from the live inputs, used only at accept.
   // The sign-extending cast lets the adder wrap naturally modulo 2^ADDR_WIDTH.
   always_comb begin
      base_sel   = use_iy ? reg_iy : reg_ix;
      disp_ext   = ADDR_WIDTH'($signed(disp));
      ea_calc    = base_sel + disp_ext;
      wdata_calc = (mode == MODE_ST_IMM) ? imm : src_data;
   end

   // Detect the edge that moves into MEM, either straight from IDLE when there
   // is no address delay or at the end of the ADDR countdown. In IDLE the live
   // inputs are used because the latches are only being loaded on that edge.
   always_comb begin
      mem_enter = 1'b0;
      nxt_mode  = mode_q;
      nxt_ea    = ea_q;
      nxt_wdata = wdata_q;
      if (state == ST_IDLE) begin
         nxt_mode  = mode;
         nxt_ea    = ea_calc;
         nxt_wdata = wdata_calc;
         mem_enter = start && (mode != MODE_ILLEGAL) && (ADDR_DELAY == 0);
      end else if (state == ST_ADDR) begin
         mem_enter = (acnt == '0);
      end
   end

   // Sequencer: state, latched operands, counters and every registered output.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         mode_q    <= MODE_ST_REG;
         ea_q      <= '0;
         wdata_q   <= '0;
         acnt      <= '0;
         tcnt      <= '0;
         busy      <= 1'b0;
         mem_addr  <= '0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_wdata <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         rd_we     <= 1'b0;
         rd_data   <= '0;
         ip_delta  <= '0;
      end else begin
         // Completion flags are single-cycle pulses unless set below.
         done     <= 1'b0;
         err      <= 1'b0;
         rd_we    <= 1'b0;
         ip_delta <= '0;

         case (state)
            ST_IDLE: begin
               if (start) begin
                  busy    <= 1'b1;
                  mode_q  <= mode;
                  ea_q    <= ea_calc;
                  wdata_q <= wdata_calc;
                  if (mode == MODE_ILLEGAL) begin
                     // Illegal op skips the bus entirely and completes next cycle.
                     state <= ST_DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else if (ADDR_DELAY > 0) begin
                     state <= ST_ADDR;
                     acnt  <= ACNT_LOAD;
                  end else begin
                     state <= ST_MEM;
                  end
               end
            end

            ST_ADDR: begin
               if (acnt == '0) begin
                  state <= ST_MEM;
               end else begin
                  acnt <= acnt - 1'b1;
               end
            end

            ST_MEM: begin
               // Only the last T-state looks at mem_wait; earlier ones always advance.
               if (tcnt == TCNT_LAST) begin
                  if (!mem_wait) begin
                     mem_rd   <= 1'b0;
                     mem_wr   <= 1'b0;
                     state    <= ST_DONE;
                     done     <= 1'b1;
                     rd_we    <= (mode_q == MODE_LD_REG);
                     ip_delta <= ip_for(mode_q);
                     if (mode_q == MODE_LD_REG) begin
                        rd_data <= mem_rdata;
                     end
                  end
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end

            ST_DONE: begin
               // start is deliberately not looked at here.
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase

         // Strobes and bus address launch from a register, so they are glitch-free
         // and rd/wr are mutually exclusive by construction of nxt_mode.
         if (mem_enter) begin
            tcnt     <= TCNT_FIRST;
            mem_addr <= nxt_ea;
            mem_rd   <= (nxt_mode == MODE_LD_REG);
            mem_wr   <= (nxt_mode != MODE_LD_REG);
            if (nxt_mode != MODE_LD_REG) begin
               mem_wdata <= nxt_wdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_z80_idx_mem_seq.sv
// Directed bench for z80_idx_mem_seq: a default-parameter instance for the
// main operations and a 20-bit / no-delay / 2-T-state instance for the sweep.
`timescale 1ns/1ps

module tb_z80_idx_mem_seq;

   localparam int D = 5;
   localparam int T = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // ---------------- instance A (defaults) ----------------
   logic        start, use_iy, busy, mem_rd, mem_wr, mem_wait, done, err, rd_we;
   logic [1:0]  mode;
   logic [15:0] reg_ix, reg_iy, mem_addr;
   logic [7:0]  disp, src_data, imm, mem_wdata, mem_rdata, rd_data;
   logic [2:0]  ip_delta;

   z80_idx_mem_seq dut_a (
      .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .use_iy(use_iy),
      .reg_ix(reg_ix), .reg_iy(reg_iy), .disp(disp), .src_data(src_data), .imm(imm),
      .busy(busy), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_wait(mem_wait),
      .done(done), .err(err), .rd_we(rd_we), .rd_data(rd_data), .ip_delta(ip_delta)
   );

   // ---------------- instance B (sweep) ----------------
   logic        b_start, b_use_iy, b_busy, b_mem_rd, b_mem_wr, b_mem_wait, b_done, b_err, b_rd_we;
   logic [1:0]  b_mode;
   logic [19:0] b_reg_ix, b_reg_iy, b_mem_addr;
   logic [7:0]  b_disp, b_src_data, b_imm, b_mem_wdata, b_mem_rdata, b_rd_data;
   logic [2:0]  b_ip_delta;

   z80_idx_mem_seq #(.ADDR_WIDTH(20), .ADDR_DELAY(0), .MEM_TSTATES(2)) dut_b (
      .clk(clk), .reset_n(reset_n), .start(b_start), .mode(b_mode), .use_iy(b_use_iy),
      .reg_ix(b_reg_ix), .reg_iy(b_reg_iy), .disp(b_disp), .src_data(b_src_data), .imm(b_imm),
      .busy(b_busy), .mem_addr(b_mem_addr), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_wait(b_mem_wait),
      .done(b_done), .err(b_err), .rd_we(b_rd_we), .rd_data(b_rd_data), .ip_delta(b_ip_delta)
   );

   // ---------------- scoreboard ----------------
   // Entry layout: [23:16] done cycle, [12] err, [11] rd_we, [10:8] ip_delta, [7:0] rd_data
   logic [31:0] exp_q[$];
   logic [7:0]  last_rd;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Launches one op on instance A, pushes its expected result, then walks the
   // cycles checking strobes and popping the expectation when done appears.
   task automatic run_op(input logic [1:0] m, input logic iy, input logic [15:0] ix_v,
                         input logic [15:0] iy_v, input logic [7:0] d, input logic [7:0] s,
                         input logic [7:0] n, input logic [7:0] rdv, input int nwait);
      logic [15:0] base, ea;
      logic [7:0]  wd;
      logic [2:0]  ipd;
      logic [31:0] e;
      int          first, last_t, dcyc;
      logic        strobe, seen;
      base   = iy ? iy_v : ix_v;
      ea     = base + {{8{d[7]}}, d};
      wd     = (m == 2'd2) ? n : s;
      ipd    = (m == 2'd2) ? 3'd4 : ((m == 2'd3) ? 3'd0 : 3'd3);
      first  = D + 1;
      last_t = D + T;
      dcyc   = (m == 2'd3) ? 1 : D + T + nwait + 1;
      if (m == 2'd1) last_rd = rdv;
      exp_q.push_back({8'd0, 8'(dcyc), 3'd0, (m == 2'd3), (m == 2'd1), ipd, last_rd});

      @(negedge clk);
      mode = m; use_iy = iy; reg_ix = ix_v; reg_iy = iy_v; disp = d; src_data = s; imm = n;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      // Operands must already be latched; scramble the inputs.
      mode = 2'($urandom); use_iy = 1'($urandom); reg_ix = 16'($urandom); reg_iy = 16'($urandom);
      disp = 8'($urandom); src_data = 8'($urandom); imm = 8'($urandom);

      seen = 1'b0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         @(negedge clk);
         // Wait is also raised in the first T-state, where it must be ignored.
         mem_wait  = (m != 2'd3) && (c == first || (c >= last_t && c < last_t + nwait));
         mem_rdata = (c == last_t + nwait) ? rdv : 8'($urandom);
         strobe = (m != 2'd3) && (c >= first) && (c <= last_t + nwait);
         chk("mem_wr", mem_wr, strobe && (m != 2'd1));
         chk("mem_rd", mem_rd, strobe && (m == 2'd1));
         chk("busy", busy, 1);
         if (strobe) chk("mem_addr", mem_addr, ea);
         if (strobe && m != 2'd1) chk("mem_wdata", mem_wdata, wd);
         if (done) begin
            chk("queue_depth", exp_q.size(), 1);
            e = exp_q.pop_front();
            chk("done_cycle", c, e[23:16]);
            chk("err", err, e[12]);
            chk("rd_we", rd_we, e[11]);
            chk("ip_delta", ip_delta, e[10:8]);
            chk("rd_data", rd_data, e[7:0]);
            seen = 1'b1;
         end
      end
      chk("done_seen", seen, 1);
      mem_wait = 1'b0;
      @(negedge clk);
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      chk("post_rd", mem_rd, 0);
      chk("post_wr", mem_wr, 0);
      chk("rd_hold", rd_data, last_rd);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset_n = 1'b0; start = 1'b0; mode = '0; use_iy = 1'b0; reg_ix = '0; reg_iy = '0;
      disp = '0; src_data = '0; imm = '0; mem_rdata = '0; mem_wait = 1'b0;
      b_start = 1'b0; b_mode = '0; b_use_iy = 1'b0; b_reg_ix = '0; b_reg_iy = '0;
      b_disp = '0; b_src_data = '0; b_imm = '0; b_mem_rdata = '0; b_mem_wait = 1'b0;
      last_rd = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);       chk("rst_rd", mem_rd, 0);
      chk("rst_wr", mem_wr, 0);       chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0); chk("rst_done", done, 0);
      chk("rst_err", err, 0);         chk("rst_rd_we", rd_we, 0);
      chk("rst_rd_data", rd_data, 0); chk("rst_ip", ip_delta, 0);
      chk("rst_b_busy", b_busy, 0);   chk("rst_b_addr", b_mem_addr, 0);
      reset_n = 1'b1;

      // Store register, defaults
      run_op(2'd0, 1'b0, 16'h1000, 16'h0000, 8'h05, 8'hA5, 8'h00, 8'h00, 0);
      // Load from IY, negative displacement, two wait states
      run_op(2'd1, 1'b1, 16'h0000, 16'h2000, 8'hFE, 8'h00, 8'h00, 8'h3C, 2);
      // Store immediate across the top of the address space
      run_op(2'd2, 1'b0, 16'hFFFF, 16'h0000, 8'h01, 8'h00, 8'h77, 8'h00, 0);
      // Negative displacement wrapping below zero
      run_op(2'd0, 1'b0, 16'h0005, 16'h0000, 8'hF0, 8'h5A, 8'h00, 8'h00, 1);
      // Illegal mode
      run_op(2'd3, 1'b0, 16'h1234, 16'h0000, 8'h10, 8'h00, 8'h00, 8'h00, 0);
      // A few random operations
      for (int k = 0; k < 4; k++) begin
         run_op(2'($urandom_range(0, 3)), 1'($urandom), 16'($urandom), 16'($urandom),
                8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3));
      end

      // Reset in the middle of the memory cycle
      @(negedge clk);
      mode = 2'd0; use_iy = 1'b0; reg_ix = 16'h3000; disp = 8'h10; src_data = 8'h11;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (D + 1) @(negedge clk);
      chk("abort_pre_wr", mem_wr, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_wr", mem_wr, 0);
      chk("abort_rd", mem_rd, 0);
      chk("abort_busy", busy, 0);
      chk("abort_addr", mem_addr, 0);
      last_rd = 8'h00;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk("abort_no_done", done, 0);
         chk("abort_no_wr", mem_wr, 0);
         if (c == 3) reset_n = 1'b1;
      end
      // Same store as the first case: must behave exactly as from reset
      run_op(2'd0, 1'b0, 16'h1000, 16'h0000, 8'h05, 8'hA5, 8'h00, 8'h00, 0);

      // Sweep instance: 20-bit addresses, no ADDR state, 2 T-states, start held.
      // EA = 0x00010 + sext(0x80) = 0xFFF90. Accepted at edge 0 and again at edge 4.
      @(negedge clk);
      b_mode = 2'd0; b_use_iy = 1'b1; b_reg_ix = 20'h12345; b_reg_iy = 20'h00010;
      b_disp = 8'h80; b_src_data = 8'h5A; b_start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         chk("b_busy", b_busy, (c != 4) && (c != 8));
         chk("b_done", b_done, (c == 3) || (c == 7));
         chk("b_wr", b_mem_wr, (c == 1) || (c == 2) || (c == 5) || (c == 6));
         chk("b_rd", b_mem_rd, 0);
         if (b_mem_wr) begin
            chk("b_addr", b_mem_addr, 20'hFFF90);
            chk("b_wdata", b_mem_wdata, 8'h5A);
         end
         if (b_done) chk("b_ip", b_ip_delta, 3);
         if (c == 5) b_start = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
